// File: rtl/disp_pattern_gen_if.sv
// rtl/disp_pattern_gen_if.sv - row-word write port between pattern source and table RAM
//
// Signals:
//   wr_valid  source -> RAM  a row word is presented
//   wr_ready  RAM -> source  the RAM accepts the word this cycle
//   addr      source -> RAM  row address of the presented word
//   data_out  source -> RAM  row word
// Modports: master (pattern source), slave (RAM side).
interface disp_pattern_gen_if #(
    parameter int ADDR_W = 4,
    parameter int COLS   = 10
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] addr;
    logic [COLS-1:0]   data_out;

    modport master (
        output wr_valid,
        output addr,
        output data_out,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  addr,
        input  data_out,
        output wr_ready
    );
endinterface

// File: rtl/disp_pattern_gen.sv
// rtl/disp_pattern_gen.sv - animated test-pattern frame writer for the game-table RAM
//
// Ports:
//   clk_40M     in   system clock
//   rst         in   synchronous active-high reset
//   step        in   one-cycle request for a new frame
//   hold        in   blocks the start of a new frame while high
//   mode        in   pattern select: 0 walk, 1 checker, 2 fill, 3 clear
//   wr          if   row-word write port (master side)
//   busy        out  a frame is in progress
//   frame_done  out  one-cycle pulse after the last row is accepted
//   frame_cnt   out  completed-frame count, wraps
module disp_pattern_gen #(
    parameter int ROWS   = 10,
    parameter int COLS   = 10,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic                  clk_40M,
    input  logic                  rst,
    input  logic                  step,
    input  logic                  hold,
    input  logic [1:0]            mode,
    disp_pattern_gen_if.master    wr,
    output logic                  busy,
    output logic                  frame_done,
    output logic [CNT_W-1:0]      frame_cnt
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_WRITE = 1'b1;

    localparam logic [1:0] MODE_WALK    = 2'd0;
    localparam logic [1:0] MODE_CHECKER = 2'd1;
    localparam logic [1:0] MODE_FILL    = 2'd2;

    localparam int PH_W = $clog2(COLS);
    // Wide enough for row + phase without overflow.
    localparam int SW   = ADDR_W + $clog2(COLS) + 1;

    // r+p is at most ROWS+COLS-2, so this many compare-subtract stages
    // always reduce it below COLS.
    localparam int MOD_ITERS  = (ROWS + COLS) / COLS + 1;
    // phase < COLS, reduced modulo ROWS+1 for the fill threshold.
    localparam int FILL_ITERS = COLS / (ROWS + 1) + 1;

    localparam logic [SW-1:0]     COLS_S    = SW'(COLS);
    localparam logic [SW-1:0]     ROWS_S    = SW'(ROWS);
    localparam logic [SW-1:0]     ROWS1_S   = SW'(ROWS + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROWS - 1);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(COLS - 1);

    logic [0:0]        state_q,   state_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [COLS-1:0]   data_q,    data_d;
    logic [1:0]        mode_q,    mode_d;
    logic [PH_W-1:0]   phase_q,   phase_d;
    logic              pending_q, pending_d;
    logic              done_q,    done_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;

    logic beat;
    logic last_row;

    // Row word for row r at phase p under pattern m.
    function automatic logic [COLS-1:0] pattern(
        input logic [1:0]        m,
        input logic [ADDR_W-1:0] r,
        input logic [PH_W-1:0]   p
    );
        logic [SW-1:0]   rs;
        logic [SW-1:0]   idx;
        logic [SW-1:0]   pm;
        logic [SW-1:0]   thr;
        logic [COLS-1:0] row;
        rs  = SW'(r);
        idx = rs + SW'(p);
        pm  = SW'(p);
        thr = '0;
        row = '0;
        case (m)
            MODE_WALK: begin
                for (int k = 0; k < MOD_ITERS; k++) begin
                    if (idx >= COLS_S) begin
                        idx = idx - COLS_S;
                    end
                end
                row = COLS'(1) << idx;
            end
            MODE_CHECKER: begin
                // Parity of r+c+p only depends on the low bits.
                for (int c = 0; c < COLS; c++) begin
                    row[c] = r[0] ^ p[0] ^ c[0];
                end
            end
            MODE_FILL: begin
                for (int k = 0; k < FILL_ITERS; k++) begin
                    if (pm >= ROWS1_S) begin
                        pm = pm - ROWS1_S;
                    end
                end
                thr = ROWS_S - pm;
                row = (rs >= thr) ? '1 : '0;
            end
            default: row = '0;
        endcase
        return row;
    endfunction

    assign beat     = (state_q == S_WRITE) && wr.wr_ready;
    assign last_row = (addr_q == LAST_ADDR);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        mode_d    = mode_q;
        phase_d   = phase_q;
        pending_d = pending_q;
        done_d    = 1'b0;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (!hold && (step || pending_q)) begin
                    state_d   = S_WRITE;
                    mode_d    = mode;
                    addr_d    = '0;
                    pending_d = 1'b0;
                    // Row 0 is built from the incoming mode since mode_q
                    // is only loaded on this same edge.
                    data_d    = pattern(mode, '0, phase_q);
                end else if (step) begin
                    pending_d = 1'b1;
                end
            end
            S_WRITE: begin
                if (step) begin
                    pending_d = 1'b1;
                end
                if (beat) begin
                    if (last_row) begin
                        state_d = S_IDLE;
                        addr_d  = '0;
                        data_d  = '0;
                        done_d  = 1'b1;
                        cnt_d   = cnt_q + CNT_W'(1);
                        phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                        data_d = pattern(mode_q, addr_q + ADDR_W'(1), phase_q);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_40M) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            mode_q    <= '0;
            phase_q   <= '0;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            mode_q    <= mode_d;
            phase_q   <= phase_d;
            pending_q <= pending_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
        end
    end

    assign wr.wr_valid = (state_q == S_WRITE);
    assign wr.addr     = addr_q;
    assign wr.data_out = data_q;
    assign busy        = (state_q == S_WRITE);
    assign frame_done  = done_q;
    assign frame_cnt   = cnt_q;

endmodule

// File: doc/disp_pattern_gen.md
Name: disp_pattern_gen

Overview:
- Parametrised test-pattern source for the game-table display RAM. Lets the VGA/display path be brought up without the game FSM.
- On each step pulse it streams one full frame, ROWS row words of COLS bits, over a valid/ready write port into the table RAM.
- The mode input selects one of four patterns. A phase counter animates the pattern from frame to frame.
- Sits where GameRAMControll normally drives the table RAM write port; a top-level mux selects between the two.

Parameters:
- ROWS, 10: rows per frame (table RAM depth used). Must be 2..2^ADDR_W.
- COLS, 10: bits per row word (table width). Must be ≥2.
- ADDR_W, 4: row address width.
- CNT_W, 8: frame counter width.

Ports:
- clk_40M  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- step  in  1  one-cycle pulse requesting a new frame; already synchronised to clk_40M.
- hold  in  1  while high, no new frame may start.
- mode  in  2  pattern select: 0 walk, 1 checker, 2 fill, 3 clear.
- wr_valid  out  1  a row word is presented.
- wr_ready  in  1  the RAM side accepts the word this cycle.
- addr  out  ADDR_W  row address of the presented word.
- data_out  out  COLS  row word.
- busy  out  1  a frame is in progress.
- frame_done  out  1  one-cycle pulse after the last row is accepted.
- frame_cnt  out  CNT_W  count of completed frames; wraps modulo 2^CNT_W.

Behaviour:
- Reset (clk_40M edge with rst=1): every output is 0. State=IDLE, phase=0, pending=0, mode_q=0. Reset mid-frame abandons the frame with no frame_done. A step arriving in the same cycle as rst is discarded.
- States:
  - IDLE: wr_valid=0, busy=0.
  - WRITE: wr_valid=1, busy=1.
- IDLE→WRITE occurs when hold=0 and (step=1 or pending=1).
  - On that edge: mode_q<=mode, addr<=0, pending<=0.
  - wr_valid is high on the next cycle (1-cycle latency from step).
- Step during WRITE, or during IDLE with hold=1: sets pending. Only one pending step is kept; extra steps are dropped.
- Handshake:
  - A beat transfers on a cycle with wr_valid&wr_ready.
  - addr and data_out hold stable while wr_valid=1 and wr_ready=0.
  - wr_valid never drops mid-frame.
  - Back-to-back ready gives one row per cycle.
- Beat at addr<ROWS-1: addr<=addr+1.
- Beat at addr=ROWS-1:
  - state<=IDLE, wr_valid<=0, addr<=0.
  - frame_done=1 for exactly the next cycle.
  - frame_cnt<=frame_cnt+1.
  - phase<=(phase==COLS-1)?0:phase+1.
- Pending at frame end with hold=0: IDLE is visited for exactly one cycle (frame_done high), then WRITE resumes. The next frame uses the updated phase and samples mode at that IDLE→WRITE edge.
- hold does not affect a frame already in WRITE.
- Pattern for row r, phase p, bit c (bit 0 = LSB); computed from mode_q, so a mode change mid-frame has no effect:
  - walk (0): only bit ((r+p) mod COLS) set. At p=0, row 0 is 0…01 and row 9 is 10…0 for 10x10.
  - checker (1): bit c = (r+c+p) & 1.
  - fill (2): row is all ones if r ≥ ROWS−(p mod (ROWS+1)), else all zeros. Rows fill bottom-up as phase grows.
  - clear (3): all zeros.
- Arithmetic:
  - (r+p) mod COLS is computed in ADDR_W+⌈log2 COLS⌉+1 bits, with repeated compare-subtract unrolled to the bound set by ROWS+COLS; no divider.
  - addr never exceeds ROWS−1.
- data_out is registered (updated with addr) and must not glitch combinationally from mode.

Test Plan:
- Reset and single frame, walk: rst 2 cycles, then step with mode=0 and wr_ready=1 constant. Expect wr_valid high one cycle after step for 10 cycles. addr runs 0..9 with data_out 0x001,0x002,…,0x200. Then frame_done for 1 cycle, frame_cnt=1.
- Backpressure: mode=1, phase=0, wr_ready toggling 1,0,0,1,…. addr/data hold while ready=0. Row0=0x2AA, row1=0x155 alternating. Exactly 10 beats, one frame_done.
- Pending and phase: three steps during one frame with mode=0. Exactly one extra frame follows after 1 IDLE cycle. Second frame row0=0x002 (phase=1), frame_cnt=2.
- Hold: hold=1 with a step applied. No wr_valid. Release hold after 50 cycles → frame starts on the next cycle.
- Fill and clear: mode=2 after 3 completed frames (p=3). Rows 7..9 = 0x3FF, rows 0..6 = 0. Then mode=3 → all rows 0.
- Reset mid-frame and wrap: assert rst at addr=4 → outputs 0, no frame_done. With CNT_W=2, 5 frames → frame_cnt=1. After 10 frames phase wraps to 0, so row0=0x001.
